// File: rtl/alarm_io_pkg.sv
// Shared constants and types for the edit-key / mode-switch conditioner.
// Imported by the debouncer and the top-level repeat logic.
package alarm_io_pkg;

    localparam int NUM_KEYS     = 2;
    localparam int NUM_SWITCHES = 3;

    localparam int DEF_DEBOUNCE_CYCLES      = 500000;
    localparam int DEF_REPEAT_DELAY_CYCLES  = 25000000;
    localparam int DEF_REPEAT_PERIOD_CYCLES = 5000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    // Counter width able to hold max(a, b) - 1, never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One raw input: 2-flop synchronizer, optional inversion, and a
// hold-time debouncer that publishes the accepted level.
module debounce_bit
    import alarm_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          sampled;
    logic [CW-1:0] cnt;

    assign sampled = sync2 ^ INVERT;

    // Synchronizer resets to the released raw level so a held key re-debounces.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= INVERT;
            sync2 <= INVERT;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sampled == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sampled;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/edit_input_conditioner.sv
// Debounced edit keys with press/auto-repeat strobes, plus debounced
// mode switches, for the CPU PIO blocks.
module edit_input_conditioner
    import alarm_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [1:0] btn_raw_n,
    input  logic [2:0] sw_raw,
    output logic [1:0] btn_edit_export,
    output logic [1:0] btn_pulse,
    output logic [2:0] sw_states_export
);

    localparam int RCW =
        cnt_width(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD_CYCLES - 1);

    logic [NUM_KEYS-1:0]     key_acc;
    logic [NUM_SWITCHES-1:0] sw_acc;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : gen_key_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INVERT         (1'b1)
        ) u_db (
            .clk  (clk_clk),
            .rst  (reset_reset),
            .raw  (btn_raw_n[gi]),
            .level(key_acc[gi])
        );
    end

    for (genvar gs = 0; gs < NUM_SWITCHES; gs++) begin : gen_sw_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INVERT         (1'b0)
        ) u_db (
            .clk  (clk_clk),
            .rst  (reset_reset),
            .raw  (sw_raw[gs]),
            .level(sw_acc[gs])
        );
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sw_states_export <= '0;
        end else begin
            sw_states_export <= sw_acc;
        end
    end

    for (genvar gk = 0; gk < NUM_KEYS; gk++) begin : gen_key
        rep_state_t     state;
        logic [RCW-1:0] cnt;
        logic           level_q;
        logic           pulse_q;

        assign btn_edit_export[gk] = level_q;
        assign btn_pulse[gk]       = pulse_q;

        // Level and pulse are registered together so the strobe lands
        // on the first cycle the exported level reads pressed.
        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                level_q <= key_acc[gk];
                pulse_q <= 1'b0;
                unique case (state)
                    ST_IDLE: begin
                        cnt <= '0;
                        if (key_acc[gk]) begin
                            state   <= ST_DELAY;
                            pulse_q <= 1'b1;
                        end
                    end
                    ST_DELAY: begin
                        if (!key_acc[gk]) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else if (cnt == DELAY_LAST) begin
                            state   <= ST_REPEAT;
                            cnt     <= '0;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt <= cnt + RCW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!key_acc[gk]) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else if (cnt == PERIOD_LAST) begin
                            cnt     <= '0;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt <= cnt + RCW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
